// File: rtl/bypass_pkg.sv
// bypass_pkg: shared MA state encoding, load funct3 codes and alignment check for bypass_src.
package bypass_pkg;
  typedef enum logic [1:0] {MA_EMPTY, MA_ALU, MA_LD_WAIT, MA_LD_DONE} ma_state_e;
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;
  // f3[1:0] encodes log2 of the access size in bytes
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    return f3[1:0] == 2'd1 ? a[0] : f3[1:0] == 2'd2 ? |a[1:0] : f3[1:0] == 2'd3 ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/bypass_src_load_ext.sv
// load_ext: sign/zero-extends right-justified load data according to funct3.
//   f3_i    load funct3 (LB..LWU; 111 yields zero)
//   rdata_i raw read data from data memory
//   data_o  extended XLEN result
module load_ext import bypass_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      f3_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);
  always_comb begin
    data_o = f3_i == LD_B  ? {{(XLEN-8){rdata_i[7]}}, rdata_i[7:0]} :
             f3_i == LD_H  ? {{(XLEN-16){rdata_i[15]}}, rdata_i[15:0]} :
             f3_i == LD_W  ? {{(XLEN-32){rdata_i[31]}}, rdata_i[31:0]} :
             f3_i == LD_D  ? rdata_i :
             f3_i == LD_BU ? {{(XLEN-8){1'b0}}, rdata_i[7:0]} :
             f3_i == LD_HU ? {{(XLEN-16){1'b0}}, rdata_i[15:0]} :
             f3_i == LD_WU ? {{(XLEN-32){1'b0}}, rdata_i[31:0]} : '0;
  end
endmodule

// File: rtl/bypass_src.sv
// bypass_src: MA/WB stage registers sourcing the operand-bypass bus, with load handshake and load-use stall.
//   ex_*                 instruction offered by EX; ex_ready accepts it, flush drops it
//   id_rs1/id_rs2        ID sources checked for load-use hazard -> hazard_stall
//   mem_req/addr/f3/ack  level request held until a one-cycle ack with mem_rdata
//   ma_*/wb_*            bypass sources (rd=0, data=0 when the stage is a bubble)
//   rf_we/waddr/wdata    register-file write from WB
//   BYPASS_MISALIGN_EN   adds ld_misalign/ld_bad_addr and suppresses misaligned loads
module bypass_src import bypass_pkg::*; #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [RAW-1:0]  ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_ld_f3,
  output logic            ex_ready,
  input  logic            flush,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  output logic            hazard_stall,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [2:0]      mem_f3,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [RAW-1:0]  ma_rd,
  output logic [XLEN-1:0] ma_data,
  output logic [RAW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef BYPASS_MISALIGN_EN
  ,
  output logic            ld_misalign,
  output logic [XLEN-1:0] ld_bad_addr
`endif
);
  ma_state_e state_q, state_d;
  logic [RAW-1:0] ma_rd_q, ma_rd_d, wb_rd_q;
  logic [XLEN-1:0] ma_data_q, ma_data_d, wb_data_q, addr_q, addr_d, ld_data;
  logic [2:0] f3_q, f3_d;
  logic wb_valid_q, waiting, accept, bad, take;
  assign waiting = state_q == MA_LD_WAIT;
  assign accept = ex_valid & ex_ready & ~flush;
`ifdef BYPASS_MISALIGN_EN
  logic mis_q;
  logic [XLEN-1:0] bad_addr_q;
  assign bad = ex_is_load & misaligned(ex_ld_f3, ex_result[2:0]);
  assign ld_misalign = mis_q;
  assign ld_bad_addr = bad_addr_q;
  always_ff @(posedge clk) begin
    mis_q <= ~rst & accept & bad;
    bad_addr_q <= rst ? '0 : accept & bad ? ex_result : bad_addr_q;
  end
`else
  assign bad = 1'b0;
`endif
  assign take = accept & ~bad;
  load_ext #(.XLEN(XLEN)) u_ext (.f3_i(f3_q), .rdata_i(mem_rdata), .data_o(ld_data));
  always_ff @(posedge clk) begin
    state_q <= rst ? MA_EMPTY : state_d;
  end
  always_comb begin
    state_d = waiting ? (mem_ack ? MA_LD_DONE : MA_LD_WAIT) :
              take ? (ex_is_load ? MA_LD_WAIT : MA_ALU) : MA_EMPTY;
  end
  always_comb begin
    ex_ready = ~waiting;
    mem_req = waiting;
    mem_addr = addr_q;
    mem_f3 = f3_q;
    hazard_stall = waiting | (ex_valid & ex_is_load & |ex_rd & (ex_rd == id_rs1 | ex_rd == id_rs2));
    ma_rd = ma_rd_q;
    ma_data = ma_data_q;
    wb_rd = wb_rd_q;
    wb_data = wb_data_q;
    rf_we = wb_valid_q & |wb_rd_q;
    rf_waddr = wb_rd_q;
    rf_wdata = wb_data_q;
  end
  // ma_data stays zero while the load is outstanding so a stale value never forwards
  always_comb begin
    ma_rd_d = waiting ? ma_rd_q : take ? ex_rd : '0;
    ma_data_d = waiting ? (mem_ack ? ld_data : '0) : take & ~ex_is_load ? ex_result : '0;
    addr_d = take ? ex_result : addr_q;
    f3_d = take ? ex_ld_f3 : f3_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ma_rd_q <= '0;
      ma_data_q <= '0;
      addr_q <= '0;
      f3_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      ma_rd_q <= ma_rd_d;
      ma_data_q <= ma_data_d;
      addr_q <= addr_d;
      f3_q <= f3_d;
      wb_valid_q <= ~waiting & state_q != MA_EMPTY;
      wb_rd_q <= waiting ? '0 : ma_rd_q;
      wb_data_q <= waiting ? '0 : ma_data_q;
    end
  end
endmodule
